// File: rtl/bcd_stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl_if
//   Bundles the signals between the stopwatch controller, the button logic,
//   the cascaded BCD counter and the 7-segment display path.
//
//   Button side (single-cycle, already synchronised pulses):
//     start_stop, lap, clear
//   Counter side:
//     digit_001/010/100  live counter digits into the controller
//     sync_clr           registered synchronous clear to the counter
//     count_enable       increment request to the counter units digit
//   Display / status side:
//     disp_001/010/100   registered display digits
//     running, lap_active, overflow   state flags
//
//   Modports:
//     slave  - the controller itself
//     master - the surrounding system (buttons, counter, display)
// ---------------------------------------------------------------------------
interface bcd_stopwatch_ctrl_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] digit_001;
    logic [3:0] digit_010;
    logic [3:0] digit_100;
    logic       sync_clr;
    logic       count_enable;
    logic [3:0] disp_001;
    logic [3:0] disp_010;
    logic [3:0] disp_100;
    logic       running;
    logic       lap_active;
    logic       overflow;

    modport slave (
        input  start_stop, lap, clear,
        input  digit_001, digit_010, digit_100,
        output sync_clr, count_enable,
        output disp_001, disp_010, disp_100,
        output running, lap_active, overflow
    );

    modport master (
        output start_stop, lap, clear,
        output digit_001, digit_010, digit_100,
        input  sync_clr, count_enable,
        input  disp_001, disp_010, disp_100,
        input  running, lap_active, overflow
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//   Controller for a 3-digit cascaded BCD counter (000-999) used as a
//   stopwatch / event timer. Generates the counter's synchronous clear and
//   count enable, divides clk down to the count rate, and handles
//   start/stop, lap-freeze, clear and hold-at-999 overflow.
//
//   Parameters:
//     TICK_DIV  clk cycles per count (>= 1)
//
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     sw       controller side (slave modport) of bcd_stopwatch_ctrl_if
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bcd_stopwatch_ctrl_if.slave   sw
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_LAP,
        ST_OVFL
    } state_e;

    state_e        state_q,    state_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic [3:0]    lap_001_q,  lap_001_d;
    logic [3:0]    lap_010_q,  lap_010_d;
    logic [3:0]    lap_100_q,  lap_100_d;
    logic          sync_clr_q, sync_clr_d;
    logic [3:0]    disp_001_q, disp_001_d;
    logic [3:0]    disp_010_q, disp_010_d;
    logic [3:0]    disp_100_q, disp_100_d;

    logic counting;
    logic period_end;
    logic at_max;

    assign counting   = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign period_end = counting && (presc_q == PRESC_LAST);
    assign at_max     = (sw.digit_100 == 4'd9) && (sw.digit_010 == 4'd9) &&
                        (sw.digit_001 == 4'd9);

    // Next-state logic. Clear beats everything; reaching the end of a count
    // period at 999 goes to OVFL before buttons are considered so the counter
    // can never be asked to roll over; then start_stop beats lap.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        lap_001_d  = lap_001_q;
        lap_010_d  = lap_010_q;
        lap_100_d  = lap_100_q;
        sync_clr_d = sw.clear;

        // Prescaler runs only while counting; it holds across a pause so a
        // resume finishes the partially elapsed period.
        if (counting) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end

        if (sw.clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (period_end && at_max) begin
            state_d = ST_OVFL;
        end else if (sw.start_stop) begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_PAUSED;
                ST_PAUSED:  state_d = ST_RUNNING;
                ST_LAP:     state_d = ST_PAUSED;
                default:    state_d = state_q;
            endcase
        end else if (sw.lap) begin
            if (state_q == ST_RUNNING) begin
                state_d   = ST_LAP;
                lap_001_d = sw.digit_001;
                lap_010_d = sw.digit_010;
                lap_100_d = sw.digit_100;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUNNING;
            end
        end
    end

    // Display follows the live digits one cycle late, or shows the captured
    // lap value while frozen.
    always_comb begin
        disp_001_d = sw.digit_001;
        disp_010_d = sw.digit_010;
        disp_100_d = sw.digit_100;
        if (state_q == ST_LAP) begin
            disp_001_d = lap_001_q;
            disp_010_d = lap_010_q;
            disp_100_d = lap_100_q;
        end
    end

    // sync_clr resets to 1 so the counter is held clear while reset is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            lap_001_q  <= '0;
            lap_010_q  <= '0;
            lap_100_q  <= '0;
            sync_clr_q <= 1'b1;
            disp_001_q <= '0;
            disp_010_q <= '0;
            disp_100_q <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lap_001_q  <= lap_001_d;
            lap_010_q  <= lap_010_d;
            lap_100_q  <= lap_100_d;
            sync_clr_q <= sync_clr_d;
            disp_001_q <= disp_001_d;
            disp_010_q <= disp_010_d;
            disp_100_q <= disp_100_d;
        end
    end

    assign sw.sync_clr     = sync_clr_q;
    assign sw.count_enable = period_end && !at_max;
    assign sw.disp_001     = disp_001_q;
    assign sw.disp_010     = disp_010_q;
    assign sw.disp_100     = disp_100_q;
    assign sw.running      = counting;
    assign sw.lap_active   = (state_q == ST_LAP);
    assign sw.overflow     = (state_q == ST_OVFL);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//   Directed bench for bcd_stopwatch_ctrl. Instance A uses TICK_DIV=4,
//   instance B uses TICK_DIV=1. Each drives a small BCD counter model that
//   plays the role of the real cascaded counter.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bcd_stopwatch_ctrl_if ifa ();
    bcd_stopwatch_ctrl_if ifb ();

    bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (ifa.slave)
    );

    bcd_stopwatch_ctrl #(.TICK_DIV(1)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (ifb.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- counter models ----------------
    logic [11:0] cnt_a = 12'h567;
    logic [11:0] cnt_b = 12'h345;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] == 4'd9) ? 4'd0 : v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (ifa.sync_clr)          cnt_a <= 12'h000;
        else if (ifa.count_enable) cnt_a <= bcd_inc(cnt_a);
        if (ifb.sync_clr)          cnt_b <= 12'h000;
        else if (ifb.count_enable) cnt_b <= bcd_inc(cnt_b);
    end

    assign ifa.digit_001 = cnt_a[3:0];
    assign ifa.digit_010 = cnt_a[7:4];
    assign ifa.digit_100 = cnt_a[11:8];
    assign ifb.digit_001 = cnt_b[3:0];
    assign ifb.digit_010 = cnt_b[7:4];
    assign ifb.digit_100 = cnt_b[11:8];

    logic [11:0] disp_a;
    assign disp_a = {ifa.disp_100, ifa.disp_010, ifa.disp_001};

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive the selected pulses at the current negedge for exactly one cycle.
    task automatic press(input bit on_b, input bit ss, input bit lp, input bit cl);
        if (on_b) begin
            ifb.start_stop = ss; ifb.lap = lp; ifb.clear = cl;
        end else begin
            ifa.start_stop = ss; ifa.lap = lp; ifa.clear = cl;
        end
        @(negedge clk);
        ifa.start_stop = 1'b0; ifa.lap = 1'b0; ifa.clear = 1'b0;
        ifb.start_stop = 1'b0; ifb.lap = 1'b0; ifb.clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_cnt, ce_bad, n, clr_cnt;

        reset_n = 1'b0;
        ifa.start_stop = 1'b0; ifa.lap = 1'b0; ifa.clear = 1'b0;
        ifb.start_stop = 1'b0; ifb.lap = 1'b0; ifb.clear = 1'b0;

        // 1: reset held 3 clocks
        repeat (3) @(negedge clk);
        check("rst_sync_clr", ifa.sync_clr, 1);
        check("rst_digits", cnt_a, 12'h000);
        check("rst_disp", disp_a, 12'h000);
        check("rst_flags", {ifa.running, ifa.lap_active, ifa.overflow, ifa.count_enable}, 0);
        reset_n = 1'b1;
        #1;
        check("rel_sync_clr_before_edge", ifa.sync_clr, 1);
        @(negedge clk);
        check("rel_sync_clr_after_edge", ifa.sync_clr, 0);
        check("rel_digits", cnt_a, 12'h000);
        check("rel_idle", ifa.running, 0);

        // 2: start and run 40 clocks
        press(0, 1, 0, 0);
        ce_cnt = 0; ce_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (ifa.count_enable) ce_cnt++;
            if (ifa.count_enable !== ((k % 4) == 0)) ce_bad++;
            @(negedge clk);
        end
        check("run_ce_count", ce_cnt, 10);
        check("run_ce_pattern_bad", ce_bad, 0);
        check("run_digits_010", cnt_a, 12'h010);
        check("run_disp_trails", disp_a, 12'h009);
        @(negedge clk);
        check("run_disp_caught_up", disp_a, 12'h010);

        // 3: pause with presc=2, idle 100 clocks, resume
        press(0, 1, 0, 0);
        check("pause_running", ifa.running, 0);
        ce_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (ifa.count_enable) ce_cnt++;
            @(negedge clk);
        end
        check("pause_ce_none", ce_cnt, 0);
        check("pause_digits_hold", cnt_a, 12'h010);
        press(0, 1, 0, 0);
        check("resume_ce_first_cycle", ifa.count_enable, 0);
        check("resume_running", ifa.running, 1);
        @(negedge clk);
        check("resume_ce_second_cycle", ifa.count_enable, 1);
        @(negedge clk);
        check("resume_digits_011", cnt_a, 12'h011);
        check("resume_ce_drop", ifa.count_enable, 0);

        // 4: lap at 123, run to 130, release lap
        n = 0;
        while (cnt_a != 12'h123 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("lap_reach_123", cnt_a, 12'h123);
        press(0, 0, 1, 0);
        check("lap_active", ifa.lap_active, 1);
        check("lap_running_flag", ifa.running, 1);
        check("lap_disp_123", disp_a, 12'h123);
        ce_bad = 0; n = 0;
        while (cnt_a != 12'h130 && n < 200) begin
            if (disp_a !== 12'h123) ce_bad++;
            @(negedge clk);
            n++;
        end
        check("lap_reach_130", cnt_a, 12'h130);
        check("lap_disp_frozen_bad", ce_bad, 0);
        check("lap_disp_at_130", disp_a, 12'h123);
        press(0, 0, 1, 0);
        check("lap2_inactive", ifa.lap_active, 0);
        check("lap2_disp_still_frozen", disp_a, 12'h123);
        @(negedge clk);
        check("lap2_disp_live", disp_a, 12'h130);

        // 6: clear and start_stop together while running
        press(0, 1, 0, 1);
        check("clrss_sync_clr_pulse", ifa.sync_clr, 1);
        check("clrss_idle", ifa.running, 0);
        check("clrss_ce", ifa.count_enable, 0);
        @(negedge clk);
        check("clrss_sync_clr_drop", ifa.sync_clr, 0);
        check("clrss_digits", cnt_a, 12'h000);
        clr_cnt = 0; ce_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifa.sync_clr) clr_cnt++;
            if (ifa.count_enable) ce_cnt++;
            @(negedge clk);
        end
        check("clrss_no_more_clr", clr_cnt, 0);
        check("clrss_no_count", ce_cnt, 0);
        check("clrss_digits_hold", cnt_a, 12'h000);

        // 5: TICK_DIV=1 runs into overflow
        press(1, 1, 0, 0);
        check("ovf_ce_first", ifb.count_enable, 1);
        n = 0;
        while (!ifb.overflow && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("ovf_cycles", n, 1000);
        check("ovf_digits_999", cnt_b, 12'h999);
        check("ovf_ce_off", ifb.count_enable, 0);
        check("ovf_not_running", ifb.running, 0);
        press(1, 1, 0, 0);
        check("ovf_ss_ignored", {ifb.overflow, ifb.running}, 2'b10);
        repeat (3) @(negedge clk);
        check("ovf_hold_999", cnt_b, 12'h999);
        check("ovf_ce_still_off", ifb.count_enable, 0);
        press(1, 0, 0, 1);
        check("ovf_clear_exit", ifb.overflow, 0);
        check("ovf_clear_pulse", ifb.sync_clr, 1);
        @(negedge clk);
        check("ovf_clear_digits", cnt_b, 12'h000);
        press(1, 0, 1, 0);
        check("idle_lap_ignored", {ifb.lap_active, ifb.running}, 0);

        // Asynchronous reset in the middle of a count
        press(0, 1, 0, 0);
        repeat (9) @(negedge clk);
        check("mid_digits_002", cnt_a, 12'h002);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_sync_clr", ifa.sync_clr, 1);
        check("async_flags", {ifa.running, ifa.lap_active, ifa.overflow, ifa.count_enable}, 0);
        check("async_disp", disp_a, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("async_rel_sync_clr", ifa.sync_clr, 0);
        check("async_rel_digits", cnt_a, 12'h000);
        check("async_rel_idle", ifa.running, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
